// File: rtl/arm_pkg.sv
// Shared definitions for the data-memory SRAM controller.
package arm_pkg;

  // Access sequencer states: wait for a request, low halfword, high halfword, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte address that lands on SRAM halfword 0.
  localparam logic [31:0] MEM_BASE_DEF = 32'd1024;

  // Width of the external SRAM data bus.
  localparam int SRAM_DW = 16;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit accesses on an
// external asynchronous SRAM, holding ready low until the word is complete.
//
// Handshake: the MEM stage raises rd_en or wr_en and holds it (with address and
// write_data) until it sees ready=1. ready falls combinationally in the request
// cycle, stays low through both halfword phases and is high for exactly one
// cycle in DONE, where read_data is valid. Requests are sampled only in IDLE,
// so a request still held during DONE does not start a second access until the
// following IDLE cycle.
module sram_controller
  import arm_pkg::*;
#(
  parameter int          PHASE_CYCLES = 2,
  parameter logic [31:0] MEM_BASE     = MEM_BASE_DEF,
  parameter int          SRAM_AW      = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int            CW   = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  state_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         wr_q, wr_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;
  logic [31:0]  rdata_q, rdata_d;

  logic               req;
  logic               last_cyc;
  logic               in_phase;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;
  logic [SRAM_AW-2:0] word_idx;
  logic               unused_addr_bits;

  assign req      = rd_en | wr_en;
  assign last_cyc = (cnt_q == LAST);
  assign in_phase = (state_q == LO) || (state_q == HI);

  // Word index into the SRAM; the byte lane bits and bits beyond the SRAM are dropped.
  assign word_idx         = addr_q[SRAM_AW:2];
  assign unused_addr_bits = ^{addr_q[31:SRAM_AW+1], addr_q[1:0]};

  // Next-state, phase counter and latched-request logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          // A simultaneous load and store is executed as a store.
          wr_d    = wr_en;
          addr_d  = address - MEM_BASE;
          data_d  = write_data;
          state_d = LO;
        end
      end
      LO: begin
        if (last_cyc) begin
          cnt_d   = '0;
          state_d = HI;
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HI: begin
        if (last_cyc) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and latched request registers; reset abandons any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins: WE_N rises on the last cycle of each phase so address and data
  // are still stable when the SRAM latches the write.
  always_comb begin
    SRAM_ADDR = {word_idx, (state_q == HI)};
    SRAM_WE_N = ~(wr_q & in_phase & ~last_cyc);
    dq_oe     = wr_q & in_phase;
    dq_out    = (state_q == HI) ? data_q[31:16] : data_q[15:0];
  end

  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM model.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
  logic        sram_ce_n;
  logic        sram_oe_n;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_OE_N  (sram_oe_n)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] mem [0:262143];
  logic        model_rd;
  int          we_count;

  assign sram_dq = (model_rd && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

  // A low WE_N seen mid-cycle commits the bus value to the addressed halfword.
  always @(negedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr] = sram_dq;
      we_count       = we_count + 1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request at a negedge and follows it to DONE. Returns the number of
  // ready-low cycles, the SRAM address seen in the first LO and first HI cycle,
  // WE_N pulses counted and read_data in DONE. With hold=1 the request stays
  // asserted and the task returns while still in DONE.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hold,
                        output int busy, output logic [31:0] lo_a,
                        output logic [31:0] hi_a, output int we_n_pulses,
                        output logic [31:0] rdata);
    int we_before;
    @(negedge clk);
    we_before  = we_count;
    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = wdata;
    model_rd   = rd & ~wr;
    busy = 0;
    lo_a = '1;
    hi_a = '1;
    #1;
    while (!ready && busy < 20) begin
      busy++;
      if (busy == 2) lo_a = 32'(sram_addr);
      if (busy == 4) hi_a = 32'(sram_addr);
      @(negedge clk);
      #1;
    end
    rdata       = read_data;
    we_n_pulses = we_count - we_before;
    if (!hold) begin
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      model_rd = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    int          exp_we;
    logic [31:0] exp_rdata;
    logic [15:0] exp_mem_lo;
    logic [15:0] exp_mem_hi;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          busy;
    int          wep;
    logic [31:0] lo_a;
    logic [31:0] hi_a;
    logic [31:0] rdata;
    int          we_before;

    vecs[0] = '{1, 0, 32'd1024, 32'hDEADBEEF, 32'h0,     32'h1,     2, 32'h00000000, 16'hBEEF, 16'hDEAD};
    vecs[1] = '{0, 1, 32'd1024, 32'h0,        32'h0,     32'h1,     0, 32'hDEADBEEF, 16'hBEEF, 16'hDEAD};
    vecs[2] = '{0, 1, 32'd1036, 32'h0,        32'h6,     32'h7,     0, 32'hABCD1234, 16'h1234, 16'hABCD};
    vecs[3] = '{1, 1, 32'd1024, 32'h0F0F0F0F, 32'h0,     32'h1,     2, 32'hABCD1234, 16'h0F0F, 16'h0F0F};
    vecs[4] = '{1, 0, 32'd1034, 32'h11223344, 32'h4,     32'h5,     2, 32'hABCD1234, 16'h3344, 16'h1122};
    vecs[5] = '{0, 1, 32'd1032, 32'h0,        32'h4,     32'h5,     0, 32'h11223344, 16'h3344, 16'h1122};
    vecs[6] = '{0, 1, 32'd1020, 32'h0,        32'h3FFFE, 32'h3FFFF, 0, 32'hBABECAFE, 16'hCAFE, 16'hBABE};
    vecs[7] = '{0, 1, 32'd1024, 32'h0,        32'h0,     32'h1,     0, 32'h0F0F0F0F, 16'h0F0F, 16'h0F0F};

    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    mem[6]       = 16'h1234;
    mem[7]       = 16'hABCD;
    mem[18'h3FFFE] = 16'hCAFE;
    mem[18'h3FFFF] = 16'hBABE;
    we_count   = 0;
    model_rd   = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = '0;
    write_data = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_dq_oe", 32'(dut.dq_oe), 32'd0);
    chk("tied_pins", {28'd0, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven accesses
    for (int i = 0; i < 8; i++) begin
      access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 1'b0,
             busy, lo_a, hi_a, wep, rdata);
      chk($sformatf("v%0d_busy_cycles", i), 32'(busy), 32'd5);
      chk($sformatf("v%0d_lo_addr", i), lo_a, vecs[i].exp_lo);
      chk($sformatf("v%0d_hi_addr", i), hi_a, vecs[i].exp_hi);
      chk($sformatf("v%0d_we_pulses", i), 32'(wep), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_read_data", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_mem_lo", i), 32'(mem[vecs[i].exp_lo[17:0]]), 32'(vecs[i].exp_mem_lo));
      chk($sformatf("v%0d_mem_hi", i), 32'(mem[vecs[i].exp_hi[17:0]]), 32'(vecs[i].exp_mem_hi));
    end

    // Held load request: one DONE per access, an IDLE cycle between them
    access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b1, busy, lo_a, hi_a, wep, rdata);
    chk("hold_first_busy", 32'(busy), 32'd5);
    chk("hold_first_data", rdata, 32'hABCD1234);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("hold_ready_k%0d", k), 32'(ready), (k % 6 == 0) ? 32'd1 : 32'd0);
      if (k % 6 == 0) chk($sformatf("hold_data_k%0d", k), read_data, 32'hABCD1234);
    end
    rd_en    = 1'b0;
    model_rd = 1'b0;
    @(negedge clk);

    // Reset during the HI phase of a store: LO half lands, HI half does not
    @(negedge clk);
    we_before  = we_count;
    wr_en      = 1'b1;
    address    = 32'd1028;
    write_data = 32'h55556666;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("mid_rst_in_hi_addr", 32'(sram_addr), 32'd3);
    rst   = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst_dq_oe", 32'(dut.dq_oe), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_addr", 32'(sram_addr), 32'd0);
    chk("mid_rst_read_data", read_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_we_pulses", 32'(we_count - we_before), 32'd1);
    chk("mid_rst_mem2", 32'(mem[2]), 32'h6666);
    chk("mid_rst_mem3", 32'(mem[3]), 32'h0000);

    // Idle: ready high, no strobe, bus released
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle_ready_%0d", k), 32'(ready), 32'd1);
      chk($sformatf("idle_we_n_%0d", k), 32'(sram_we_n), 32'd1);
      chk($sformatf("idle_dq_oe_%0d", k), 32'(dut.dq_oe), 32'd0);
    end

    // Read back the partially written word through the controller
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, busy, lo_a, hi_a, wep, rdata);
    chk("after_rst_read_addr_lo", lo_a, 32'd2);
    chk("after_rst_read_data", rdata, 32'h00006666);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Services the MEM stage's 32-bit data-memory loads and stores against a 16-bit-wide external asynchronous SRAM (DE2-style).
- Sits directly downstream of the MEM stage and replaces the on-chip data memory.
- Drives `ready` low while an access is in progress. The top level inverts it into the pipeline-wide freeze for IF/ID/EXE/MEM registers.

Parameters:
- PHASE_CYCLES, 2: clock cycles spent per 16-bit half access; must be >= 2.
- MEM_BASE, 1024: byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  store request from MEM stage (held until ready).
- rd_en  input  1  load request from MEM stage (held until ready).
- address  input  32  byte address (ALU result).
- write_data  input  32  store value.
- read_data  output  32  load result; valid while ready=1 in DONE.
- ready  output  1  0 = busy, the pipeline must freeze.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  SRAM_AW  SRAM halfword address.
- SRAM_WE_N  output  1  write strobe, active-low.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0.

Behaviour:
- States: IDLE, LO, HI, DONE. A phase counter counts 0..PHASE_CYCLES-1 within LO and HI.
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, read_data=0.
  - SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
  - The latched op/addr/data registers clear to 0.
- IDLE with rd_en|wr_en=1:
  - Latch op, offset = address-MEM_BASE (32-bit modulo) and write_data.
  - Next state is LO.
  - If wr_en and rd_en are both 1, the access is treated as a write.
- Word index w = offset[SRAM_AW:2] (byte offset bits [1:0] ignored).
- LO phase:
  - SRAM_ADDR = {w, 1'b0}.
  - Writes drive SRAM_DQ = data[15:0].
  - Reads latch SRAM_DQ into read_data[15:0] on the edge that ends the last LO cycle.
- HI phase:
  - SRAM_ADDR = {w, 1'b1}.
  - Writes drive SRAM_DQ = data[31:16].
  - Reads latch SRAM_DQ into read_data[31:16] on the last HI edge.
- LO->HI and HI->DONE transitions occur when counter==PHASE_CYCLES-1. The counter resets to 0 at each phase change.
- SRAM_WE_N = 0 during write phases when counter < PHASE_CYCLES-1. It is 1 on the last cycle of each phase, which gives address/data hold before SRAM_ADDR changes.
- SRAM_DQ is driven only in write LO/HI; otherwise it is Z.
- DONE lasts exactly one cycle, then the state returns to IDLE unconditionally. A new request is sampled only in IDLE, so the held old request cannot retrigger.
- ready is combinational: ready = (IDLE & ~(rd_en|wr_en)) | DONE. It drops in the same cycle a request appears.
- With PHASE_CYCLES=2:
  - ready=0 for 5 cycles (request cycle + 4 phase cycles), then 1 in DONE.
  - Access latency is 2*PHASE_CYCLES+1 cycles from request to ready.
- read_data holds its value until the next read overwrites it. Writes do not modify read_data.
- Request inputs changing mid-access are ignored; only latched values are used.
- Reset mid-access: the access is abandoned immediately, outputs go to their reset values, and no further WE_N pulse occurs.
- Back-to-back requests: IDLE is entered for 1 cycle between accesses, so the minimum spacing is 2*PHASE_CYCLES+2 cycles.

Decomposition:
- Shared package (arm_pkg):
  - state enum {IDLE, LO, HI, DONE}.
  - MEM_BASE default constant.
  - SRAM data width constant 16.
- No sub-module. The phase counter and FSM are inline. Tristate is a single continuous assign.

Test Plan:
- Store 0xDEADBEEF to address 1024, then load from 1024 (SRAM behavioural model in bench):
  - Write: SRAM_ADDR 0 then 1, DQ 0xBEEF then 0xDEAD, one WE_N low cycle per phase.
  - Read: read_data=0xDEADBEEF in DONE.
  - ready low exactly 5 cycles per access.
- Load from address 1036 (SRAM model halfwords 6=0x1234, 7=0xABCD) -> SRAM_ADDR 6 then 7, read_data=0xABCD1234.
- Hold rd_en=1 through DONE and keep it asserted into IDLE -> one DONE pulse per request; a second access starts only on the IDLE sample, never two DONEs without an intervening IDLE cycle.
- Assert rst=0 during the HI phase of a store of 0x55556666 to 1028 -> immediate IDLE, WE_N=1, DQ=Z. Halfword 3 is unwritten; halfword 2=0x6666 (LO completed).
- rd_en=wr_en=1 at address 1024 with write_data=0x0F0F0F0F -> write performed (SRAM halfwords 0/1 = 0x0F0F/0x0F0F), read_data unchanged.
- Idle with no requests for 10 cycles -> ready=1, WE_N=1, DQ=Z throughout.
